// File: rtl/rf_pkg.sv
// Shared register-file definitions: geometry of the 8x8-bit file and the write-port bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_pkg;

    localparam int RF_DATA_W = 8;
    localparam int RF_ADDR_W = 3;
    localparam int RF_NREGS  = 8;
    localparam logic [RF_ADDR_W-1:0] RF_ZERO_REG = 3'd0;

    // One write-port transaction as seen by the register file.
    typedef struct packed {
        logic                 we;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin arbiter: one-hot grant to the first requester at or after ptr.
// Latency: 0 cycles (purely combinational).
// Backpressure: en=0 forces an all-zero grant.
// Ports: req[N] requests, ptr highest-priority index, en grant enable, gnt[N] one-hot grant.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt
);

    logic          found;
    logic [PW-1:0] idx;

    // Walk the ring starting at ptr; the first active request wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the register-file write port (we3/wa3/wd3) among N_REQ writers.
// Latency: grant same cycle as valid; write on the port the cycle after the transfer.
// Backpressure: hold or rst blocks all grants; ungranted requesters keep valid/addr/data stable.
// Ports: clk, rst (async, active-high), hold, req_valid/req_addr/req_data (packed per requester),
//        req_ready (one-hot grant), we3/wa3/wd3 (write port), grant_id (owner of current write),
//        stall_cnt (only when RF_ARB_STALL_CNT_EN is defined: saturating count of stalled cycles).
import rf_pkg::*;

module regfile_write_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hold,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      we3,
    output logic [ADDR_W-1:0]         wa3,
    output logic [DATA_W-1:0]         wd3,
    output logic [ID_W-1:0]           grant_id
`ifdef RF_ARB_STALL_CNT_EN
    ,
    output logic [7:0]                stall_cnt
`endif
);

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   win_id;
    logic              xfer;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    // Ready depends only on valid, pointer, hold and rst -- never on addr/data.
    rr_arbiter #(.N(N_REQ)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .en  (!hold && !rst),
        .gnt (req_ready)
    );

    // One-hot grant to index.
    always_comb begin
        win_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    assign xfer     = |req_ready;
    assign win_addr = req_addr[int'(win_id)*ADDR_W +: ADDR_W];
    assign win_data = req_data[int'(win_id)*DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            we3      <= 1'b0;
            wa3      <= '0;
            wd3      <= '0;
            grant_id <= '0;
        end else if (xfer) begin
            // Explicit wrap: N_REQ need not be a power of two.
            rr_ptr   <= (win_id == ID_W'(N_REQ-1)) ? '0 : win_id + 1'b1;
            // A write to $0 is accepted but never reaches the register file.
            we3      <= (win_addr != ADDR_W'(RF_ZERO_REG));
            wa3      <= win_addr;
            wd3      <= win_data;
            grant_id <= win_id;
        end else begin
            we3 <= 1'b0;
        end
    end

`ifdef RF_ARB_STALL_CNT_EN
    // A cycle stalls when some valid requester is left without a grant (hold included).
    logic any_stall;
    assign any_stall = |(req_valid & ~req_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (any_stall && stall_cnt != 8'hFF) begin
            stall_cnt <= stall_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
    import rf_pkg::*;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           hold;
    logic [N-1:0]   req_valid;
    logic [N*3-1:0] req_addr;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           we3;
    logic [2:0]     wa3;
    logic [7:0]     wd3;
    logic [1:0]     grant_id;
`ifdef RF_ARB_STALL_CNT_EN
    logic [7:0]     stall_cnt;
`endif

    regfile_write_arbiter #(.N_REQ(N), .DATA_W(8), .ADDR_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3),
        .grant_id  (grant_id)
`ifdef RF_ARB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register file driven by the DUT's write port.
    logic [7:0] dut_rf [8] = '{default: 8'h00};
    always @(posedge clk) begin
        if (we3) dut_rf[wa3] <= wd3;
    end

    // Behavioural reference: priority pointer, pending write, register file contents.
    int         m_ptr    = 0;
    int         m_gid    = 0;
    int         m_stall  = 0;
    int         last_win = -1;
    logic       m_we     = 1'b0;
    logic [2:0] m_wa     = 3'd0;
    logic [7:0] m_wd     = 8'd0;
    logic [7:0] mod_rf [8] = '{default: 8'h00};

    function automatic int winner();
        int idx;
        if (rst || hold) return -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        int  w;
        bit  stalled;
        if (rst) begin
            m_ptr = 0; m_gid = 0; m_stall = 0; last_win = -1;
            m_we = 1'b0; m_wa = 3'd0; m_wd = 8'd0;
        end else begin
            if (m_we) mod_rf[m_wa] = m_wd;
            w = winner();
            stalled = 1'b0;
            for (int i = 0; i < N; i++)
                if (req_valid[i] && i != w) stalled = 1'b1;
            if (stalled && m_stall < 255) m_stall++;
            last_win = w;
            if (w >= 0) begin
                m_ptr = (w + 1) % N;
                m_wa  = req_addr[w*3 +: 3];
                m_wd  = req_data[w*8 +: 8];
                m_we  = (m_wa != 3'd0);
                m_gid = w;
            end else begin
                m_we = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        int w;
        logic [3:0] er;
        w  = winner();
        er = (w < 0) ? 4'd0 : 4'(1 << w);
        chk("ready", 32'(req_ready), 32'(er));
        chk("we3", 32'(we3), 32'(m_we));
        chk("wa3", 32'(wa3), 32'(m_wa));
        chk("wd3", 32'(wd3), 32'(m_wd));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
`ifdef RF_ARB_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
        for (int r = 0; r < 8; r++)
            chk($sformatf("rf%0d", r), 32'(dut_rf[r]), 32'(mod_rf[r]));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] a, input logic [7:0] d);
        req_valid[i]      = 1'b1;
        req_addr[i*3 +: 3] = a;
        req_data[i*8 +: 8] = d;
    endtask

    initial begin
        hold = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        repeat (3) step();
        rst = 1'b0;

        // Idle after reset.
        repeat (3) begin
            @(negedge clk);
            chk("idle_we3", 32'(we3), 32'd0);
            chk("idle_wa3", 32'(wa3), 32'd0);
            chk("idle_wd3", 32'(wd3), 32'd0);
            chk("idle_ready", 32'(req_ready), 32'd0);
            step();
        end

        // Single requester 1 writes $3 = A5.
        set_req(1, 3'd3, 8'hA5);
        @(negedge clk); chk("r1_ready", 32'(req_ready), 32'b0010);
        step(); req_valid = '0;
        @(negedge clk);
        chk("r1_we3", 32'(we3), 32'd1);
        chk("r1_wa3", 32'(wa3), 32'd3);
        chk("r1_wd3", 32'(wd3), 32'hA5);
        chk("r1_gid", 32'(grant_id), 32'd1);
        step();
        @(negedge clk); chk("r1_rf3", 32'(dut_rf[3]), 32'hA5);
        step();

        // All four continuously valid from pointer 0: grants rotate 0,1,2,3,...
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 3'(i + 1), 8'($urandom));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
            if (k > 0) chk("rr_we3", 32'(we3), 32'd1);
            step();
            req_data[(k % 4)*8 +: 8] = 8'($urandom);
        end
        req_valid = '0;

        // Write to $0 is accepted but dropped.
        set_req(2, 3'd0, 8'hFF);
        @(negedge clk); chk("z_ready", 32'(req_ready), 32'b0100);
        step(); req_valid = '0;
        @(negedge clk);
        chk("z_we3", 32'(we3), 32'd0);
        chk("z_rf0", 32'(dut_rf[0]), 32'd0);
        step();

        // Hold for three cycles with requesters 0 and 3 pending.
        rst = 1'b1; step(); rst = 1'b0;
        hold = 1'b1;
        set_req(0, 3'd5, 8'h11);
        set_req(3, 3'd6, 8'h22);
        repeat (3) begin
            @(negedge clk);
            chk("h_ready", 32'(req_ready), 32'd0);
            chk("h_we3", 32'(we3), 32'd0);
            step();
        end
        hold = 1'b0;
        @(negedge clk);
        chk("h_rel_ready", 32'(req_ready), 32'b0001);
`ifdef RF_ARB_STALL_CNT_EN
        chk("h_stall", 32'(stall_cnt), 32'd3);
`endif
        step(); req_valid[0] = 1'b0;
        @(negedge clk); chk("h_next_ready", 32'(req_ready), 32'b1000);
        step(); req_valid = '0;

        // Reset one cycle after a grant to requester 2 kills the pending write.
        set_req(2, 3'd4, 8'h3C);
        step();
        chk("rs_we3_pre", 32'(we3), 32'd1);
        set_req(0, 3'd7, 8'h5A);
        #1 rst = 1'b1;
        #1;
        chk("rs_we3_async", 32'(we3), 32'd0);
        chk("rs_ready", 32'(req_ready), 32'd0);
        step(); rst = 1'b0;
        @(negedge clk); chk("rs_ptr0", 32'(req_ready), 32'b0001);

        // Randomized traffic: requesters hold requests until granted.
        repeat (3000) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_win == i) begin
                    req_valid[i]       = ($urandom_range(0, 99) < 60);
                    req_addr[i*3 +: 3] = 3'($urandom_range(0, 7));
                    req_data[i*8 +: 8] = 8'($urandom);
                end
            end
            hold = ($urandom_range(0, 9) == 0);
            if (rst) rst = 1'b0;
            else     rst = ($urandom_range(0, 199) == 0);
        end

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
